// File: rtl/beat_tempo_tracker.sv
// Beat tempo tracker: turns per-frame beat flags from the spectral-flux stage into a
// debounced beat pulse, a rolling mean beat interval and a BPM figure from an iterative divider.
module beat_tempo_tracker #(
  parameter int MAX_FLUX_LENGTH = 70,
  parameter int HIST            = 8,
  parameter int MIN_INTERVAL    = 11,
  parameter int MAX_INTERVAL    = 255,
  parameter int FRAMES_PER_MIN  = 2812
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flux_valid,
  input  logic                       beat_valid,
  input  logic [MAX_FLUX_LENGTH-1:0] flux_value,
  output logic                       beat_pulse,
  output logic [MAX_FLUX_LENGTH-1:0] beat_flux,
  output logic [7:0]                 bpm,
  output logic                       bpm_valid,
  output logic                       locked
);

  localparam int PTR_W     = $clog2(HIST);
  localparam int SUM_W     = 8 + PTR_W;
  localparam int FILL_W    = PTR_W + 1;
  localparam int DIV_STEPS = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_e;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // NOTE: every clocked process uses non-blocking (<=) assignments so all registers
  // sample their inputs on the same edge regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // Frame tick detection and beat qualification
  // ---------------------------------------------------------------------------
  logic                       flux_valid_q;
  logic [7:0]                 frame_cnt_q, frame_cnt_d;
  logic                       first_seen_q, first_seen_d;
  logic                       beat_pulse_q, beat_pulse_d;
  logic [MAX_FLUX_LENGTH-1:0] beat_flux_q, beat_flux_d;
  logic                       rec_q, rec_d;
  logic [7:0]                 hist_q [HIST];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]          fill_q, fill_d;
  logic [SUM_W-1:0]           sum_q, sum_d;

  logic       tick, beat, cnt_sat, too_short;
  logic       accept_first, accept_restart, accept_rec, accept;
  logic [7:0] rec_interval;
  logic [7:0] mean;

  assign tick         = flux_valid & ~flux_valid_q;
  assign beat         = tick & beat_valid;
  assign cnt_sat      = (frame_cnt_q == 8'(MAX_INTERVAL));
  // interval = frame_cnt + 1, so "interval < MIN" is "frame_cnt < MIN - 1"
  assign too_short    = (frame_cnt_q < 8'(MIN_INTERVAL - 1));
  assign rec_interval = frame_cnt_q + 8'd1;

  assign accept_first   = beat & ~first_seen_q;
  assign accept_restart = beat &  first_seen_q & ~too_short &  cnt_sat;
  assign accept_rec     = beat &  first_seen_q & ~too_short & ~cnt_sat;
  assign accept         = accept_first | accept_restart | accept_rec;

  assign mean   = sum_q[SUM_W-1:PTR_W];
  assign locked = (fill_q == FILL_W'(HIST));

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    first_seen_d = first_seen_q | accept;
    beat_pulse_d = accept;
    beat_flux_d  = beat_flux_q;
    rec_d        = accept_rec;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    sum_d        = sum_q;

    if (tick && !cnt_sat) frame_cnt_d = frame_cnt_q + 8'd1;

    if (accept) begin
      frame_cnt_d = '0;
      beat_flux_d = flux_value;
    end

    if (accept_rec) begin
      sum_d    = sum_q - SUM_W'(hist_q[wr_ptr_q]) + SUM_W'(rec_interval);
      wr_ptr_d = (wr_ptr_q == PTR_W'(HIST - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (!locked) fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flux_valid_q <= 1'b0;
      frame_cnt_q  <= '0;
      first_seen_q <= 1'b0;
      beat_pulse_q <= 1'b0;
      beat_flux_q  <= '0;
      rec_q        <= 1'b0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      sum_q        <= '0;
    end else begin
      flux_valid_q <= flux_valid;
      frame_cnt_q  <= frame_cnt_d;
      first_seen_q <= first_seen_d;
      beat_pulse_q <= beat_pulse_d;
      beat_flux_q  <= beat_flux_d;
      rec_q        <= rec_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      sum_q        <= sum_d;
    end
  end

  // NOTE: the history is reset even though it is a small memory, because the running
  // sum subtracts the overwritten entry and must start from a consistent all-zero state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HIST; i++) hist_q[i] <= '0;
    end else if (accept_rec) begin
      hist_q[wr_ptr_q] <= rec_interval;
    end
  end

  assign beat_pulse = beat_pulse_q;
  assign beat_flux  = beat_flux_q;

  // ---------------------------------------------------------------------------
  // Restoring divider: FRAMES_PER_MIN / mean, one quotient bit per cycle
  // ---------------------------------------------------------------------------
  state_e     state_q;
  logic [11:0] quo_q;
  logic [7:0]  rem_q;
  logic [7:0]  div_q;
  logic [3:0]  step_q;
  logic        pend_q;
  logic [7:0]  bpm_q;
  logic        bpm_valid_q;

  logic [8:0]  rem_sh;
  logic        ge;
  logic [7:0]  rem_nx;
  logic [11:0] quo_nx;
  logic [7:0]  bpm_nx;

  always_comb begin
    rem_sh = {rem_q, quo_q[11]};
    ge     = (rem_sh >= {1'b0, div_q});
    rem_nx = ge ? 8'(rem_sh - {1'b0, div_q}) : rem_sh[7:0];
    quo_nx = {quo_q[10:0], ge};
    if (div_q == 8'd0 || quo_nx[11:8] != 4'd0) bpm_nx = 8'hFF;
    else                                       bpm_nx = quo_nx[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      quo_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      step_q      <= '0;
      pend_q      <= 1'b0;
      bpm_q       <= '0;
      bpm_valid_q <= 1'b0;
    end else begin
      bpm_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rec_q && locked) begin
            quo_q   <= 12'(FRAMES_PER_MIN);
            rem_q   <= '0;
            div_q   <= mean;
            step_q  <= '0;
            state_q <= S_DIV;
          end
        end
        S_DIV: begin
          quo_q  <= quo_nx;
          rem_q  <= rem_nx;
          step_q <= step_q + 4'd1;
          if (rec_q) pend_q <= 1'b1;
          if (step_q == 4'(DIV_STEPS - 1)) begin
            bpm_q       <= bpm_nx;
            bpm_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // Any beats recorded mid-division collapse into one rerun with the newest mean.
          if (pend_q || rec_q) begin
            quo_q   <= 12'(FRAMES_PER_MIN);
            rem_q   <= '0;
            div_q   <= mean;
            step_q  <= '0;
            pend_q  <= 1'b0;
            state_q <= S_DIV;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bpm       = bpm_q;
  assign bpm_valid = bpm_valid_q;

endmodule

// File: tb/tb_beat_tempo_tracker.sv
// Bench for beat_tempo_tracker: a table of beat gaps with expected pulse/lock/BPM results,
// a scoreboard for beat pulses and BPM updates, and hand-written reset and level-hold sequences.
module tb_beat_tempo_tracker;

  localparam int FW = 70;
  localparam int HI = 3;
  localparam int LO = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          flux_valid;
  logic          beat_valid;
  logic [FW-1:0] flux_value;
  logic          beat_pulse;
  logic [FW-1:0] beat_flux;
  logic [7:0]    bpm;
  logic          bpm_valid;
  logic          locked;

  beat_tempo_tracker dut (
    .clk        (clk),
    .reset      (reset),
    .flux_valid (flux_valid),
    .beat_valid (beat_valid),
    .flux_value (flux_value),
    .beat_pulse (beat_pulse),
    .beat_flux  (beat_flux),
    .bpm        (bpm),
    .bpm_valid  (bpm_valid),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] val;
    int            cyc;
  } exp_t;

  typedef struct {
    int         gap;
    logic       pulse;
    logic       upd;
    logic [7:0] bpm;
    logic       locked;
  } vec_t;

  exp_t beat_q[$];
  exp_t bpm_q[$];
  vec_t vecs[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pulse_cnt = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  exp_t mon_b;
  exp_t mon_r;

  always @(negedge clk) begin
    if (beat_pulse) begin
      pulse_cnt++;
      if (beat_q.size() == 0) check("unexpected_beat_pulse", 80'(1), 80'(0));
      else begin
        mon_b = beat_q.pop_front();
        check("beat_flux", 80'(beat_flux), 80'(mon_b.val));
        check("beat_pulse_cycle", 80'(cyc), 80'(mon_b.cyc));
      end
    end
    if (bpm_valid) begin
      if (bpm_q.size() == 0) check("unexpected_bpm_valid", 80'(1), 80'(0));
      else begin
        mon_r = bpm_q.pop_front();
        check("bpm_value", 80'(bpm), 80'(mon_r.val));
        check("bpm_valid_cycle", 80'(cyc), 80'(mon_r.cyc));
      end
    end
  end

  // One frame starting at a falling edge: tick, beat flag for one cycle, then idle.
  task automatic frame(input logic b, input logic [FW-1:0] v,
                       input logic exp_p, input logic exp_u, input logic [7:0] exp_b);
    flux_valid = 1'b1;
    beat_valid = b;
    flux_value = v;
    if (exp_p) beat_q.push_back('{v, cyc + 1});
    if (exp_u) bpm_q.push_back('{FW'(exp_b), cyc + 14});
    @(negedge clk);
    beat_valid = 1'b0;
    repeat (HI - 1) @(negedge clk);
    flux_valid = 1'b0;
    repeat (LO) @(negedge clk);
  endtask

  function automatic logic [FW-1:0] rnd_flux();
    return {6'($urandom()), $urandom(), $urandom()};
  endfunction

  logic [7:0]    tempo_bpm [8];
  logic [FW-1:0] v;
  logic [FW-1:0] last_flux;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tempo_bpm = '{8'd127, 8'd127, 8'd133, 8'd133, 8'd133, 8'd140, 8'd140, 8'd140};

    vecs.push_back('{1, 1'b1, 1'b0, 8'd0, 1'b0});
    for (int i = 0; i < 7; i++) vecs.push_back('{23, 1'b1, 1'b0, 8'd0, 1'b0});
    vecs.push_back('{23,  1'b1, 1'b1, 8'd122, 1'b1});
    vecs.push_back('{5,   1'b0, 1'b0, 8'd122, 1'b1});
    vecs.push_back('{18,  1'b1, 1'b1, 8'd122, 1'b1});
    vecs.push_back('{300, 1'b1, 1'b0, 8'd122, 1'b1});
    vecs.push_back('{23,  1'b1, 1'b1, 8'd122, 1'b1});
    for (int i = 0; i < 8; i++) vecs.push_back('{20, 1'b1, 1'b1, tempo_bpm[i], 1'b1});

    reset      = 1'b0;
    flux_valid = 1'b0;
    beat_valid = 1'b0;
    flux_value = '0;
    last_flux  = '0;
    repeat (3) @(negedge clk);
    check("reset_beat_pulse", 80'(beat_pulse), 80'(0));
    check("reset_beat_flux",  80'(beat_flux),  80'(0));
    check("reset_bpm",        80'(bpm),        80'(0));
    check("reset_bpm_valid",  80'(bpm_valid),  80'(0));
    check("reset_locked",     80'(locked),     80'(0));
    reset = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      repeat (vecs[i].gap - 1) frame(1'b0, '0, 1'b0, 1'b0, 8'd0);
      v = rnd_flux();
      frame(1'b1, v, vecs[i].pulse, vecs[i].upd, vecs[i].bpm);
      if (vecs[i].pulse) last_flux = v;
      check($sformatf("vec%0d_bpm", i),       80'(bpm),       80'(vecs[i].bpm));
      check($sformatf("vec%0d_locked", i),    80'(locked),    80'(vecs[i].locked));
      check($sformatf("vec%0d_beat_flux", i), 80'(beat_flux), 80'(last_flux));
      check($sformatf("vec%0d_drained", i),   80'(beat_q.size() + bpm_q.size()), 80'(0));
    end

    // Reset while a division is in flight: outputs clear at once, no late bpm_valid.
    repeat (19) frame(1'b0, '0, 1'b0, 1'b0, 8'd0);
    v = rnd_flux();
    flux_valid = 1'b1;
    beat_valid = 1'b1;
    flux_value = v;
    beat_q.push_back('{v, cyc + 1});
    @(negedge clk);
    beat_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    flux_valid = 1'b0;
    #1;
    check("midreset_beat_pulse", 80'(beat_pulse), 80'(0));
    check("midreset_beat_flux",  80'(beat_flux),  80'(0));
    check("midreset_bpm",        80'(bpm),        80'(0));
    check("midreset_bpm_valid",  80'(bpm_valid),  80'(0));
    check("midreset_locked",     80'(locked),     80'(0));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("postreset_bpm",     80'(bpm), 80'(0));
    check("postreset_drained", 80'(beat_q.size() + bpm_q.size()), 80'(0));

    // Level held high with the beat flag asserted counts as a single tick.
    pulse_cnt  = 0;
    v = rnd_flux();
    flux_valid = 1'b1;
    beat_valid = 1'b1;
    flux_value = v;
    beat_q.push_back('{v, cyc + 1});
    repeat (500) @(negedge clk);
    flux_valid = 1'b0;
    beat_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("level_hold_pulses",    80'(pulse_cnt), 80'(1));
    check("level_hold_beat_flux", 80'(beat_flux), 80'(v));
    check("level_hold_locked",    80'(locked),    80'(0));
    check("level_hold_drained",   80'(beat_q.size() + bpm_q.size()), 80'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
